// File: rtl/connect4_turn_controller.sv
// Connect-4 turn controller: accepts one drop per turn, places the piece by gravity,
// then scans the landing row and column for four of the mover's colour.
module connect4_turn_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        drop_valid,
    input  logic [2:0]  drop_col,
    output logic        drop_ready,
    output logic        cur_player,
    output logic [83:0] board,
    output logic        move_err,
    output logic        win1,
    output logic        win2,
    output logic        draw,
    output logic        game_over
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PLACE  = 3'd1;
    localparam logic [2:0] S_SCAN_H = 3'd2;
    localparam logic [2:0] S_SCAN_V = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [83:0] board_q, board_d;
    logic [2:0]  height_q [7];
    logic [2:0]  height_d [7];
    logic [5:0]  moves_q, moves_d;
    logic        cur_q, cur_d;
    logic [2:0]  col_q, col_d;
    logic [2:0]  row_q, row_d;
    logic [1:0]  scan_q, scan_d;
    logic        pend_q, pend_d;
    logic        win1_q, win1_d;
    logic        win2_q, win2_d;
    logic        draw_q, draw_d;

    logic [1:0]  code;
    logic [2:0]  hsel;
    logic        hmatch;
    logic        vmatch;

    function automatic int cell_idx(input int r, input int c);
        return 2 * (7 * r + c);
    endfunction

    function automatic logic [1:0] cell_at(input logic [83:0] b, input int r, input int c);
        return b[cell_idx(r, c) +: 2];
    endfunction

    assign code = cur_q ? 2'b10 : 2'b01;

    // Column 7 falls through to a full height so it is rejected like a full column.
    always_comb begin
        hsel = 3'd6;
        for (int i = 0; i < 7; i++) begin
            if (drop_col == 3'(i)) hsel = height_q[i];
        end
    end

    always_comb begin
        hmatch = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (cell_at(board_q, int'(row_q), int'(scan_q) + k) != code) hmatch = 1'b0;
        end
        vmatch = (row_q >= 3'd3);
        for (int k = 0; k < 4; k++) begin
            if (cell_at(board_q, (row_q >= 3'd3) ? int'(row_q) - k : 3 - k, int'(col_q)) != code)
                vmatch = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        height_d = height_q;
        moves_d  = moves_q;
        cur_d    = cur_q;
        col_d    = col_q;
        row_d    = row_q;
        scan_d   = scan_q;
        pend_d   = pend_q;
        win1_d   = win1_q;
        win2_d   = win2_q;
        draw_d   = draw_q;
        if (new_game) begin
            state_d = S_IDLE;
            board_d = '0;
            for (int i = 0; i < 7; i++) height_d[i] = '0;
            moves_d = '0;
            cur_d   = 1'b0;
            scan_d  = '0;
            pend_d  = 1'b0;
            win1_d  = 1'b0;
            win2_d  = 1'b0;
            draw_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (drop_valid) begin
                        if (hsel == 3'd6) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_PLACE;
                            col_d   = drop_col;
                            row_d   = hsel;
                            pend_d  = 1'b0;
                        end
                    end
                end
                S_PLACE: begin
                    board_d[cell_idx(int'(row_q), int'(col_q)) +: 2] = code;
                    height_d[col_q] = height_q[col_q] + 3'd1;
                    moves_d = moves_q + 6'd1;
                    scan_d  = '0;
                    state_d = S_SCAN_H;
                end
                S_SCAN_H: begin
                    pend_d = pend_q | hmatch;
                    scan_d = scan_q + 2'd1;
                    if (scan_q == 2'd3) state_d = S_SCAN_V;
                end
                S_SCAN_V: begin
                    if (pend_q | vmatch) begin
                        win1_d  = ~cur_q;
                        win2_d  = cur_q;
                        state_d = S_DONE;
                    end else if (moves_q == 6'd42) begin
                        draw_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cur_d   = ~cur_q;
                        state_d = S_IDLE;
                    end
                end
                S_ERR:   state_d = S_IDLE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            board_q <= '0;
            for (int i = 0; i < 7; i++) height_q[i] <= '0;
            moves_q <= '0;
            cur_q   <= 1'b0;
            scan_q  <= '0;
            pend_q  <= 1'b0;
            win1_q  <= 1'b0;
            win2_q  <= 1'b0;
            draw_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            height_q <= height_d;
            moves_q  <= moves_d;
            cur_q    <= cur_d;
            scan_q   <= scan_d;
            pend_q   <= pend_d;
            win1_q   <= win1_d;
            win2_q   <= win2_d;
            draw_q   <= draw_d;
        end
    end

    // Landing coordinates are only consumed after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        col_q <= col_d;
        row_q <= row_d;
    end

    assign drop_ready = (state_q == S_IDLE);
    assign move_err   = (state_q == S_ERR);
    assign cur_player = cur_q;
    assign board      = board_q;
    assign win1       = win1_q;
    assign win2       = win2_q;
    assign draw       = draw_q;
    assign game_over  = win1_q | win2_q | draw_q;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Directed bench for connect4_turn_controller with a small board/turn model.
module tb_connect4_turn_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game;
    logic        drop_valid;
    logic [2:0]  drop_col;
    logic        drop_ready;
    logic        cur_player;
    logic [83:0] board;
    logic        move_err;
    logic        win1;
    logic        win2;
    logic        draw;
    logic        game_over;

    int n_vec = 0;
    int n_err = 0;

    logic [83:0] exp_board;
    int          hgt [7];
    logic        exp_cur;

    connect4_turn_controller dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .drop_valid (drop_valid),
        .drop_col   (drop_col),
        .drop_ready (drop_ready),
        .cur_player (cur_player),
        .board      (board),
        .move_err   (move_err),
        .win1       (win1),
        .win2       (win2),
        .draw       (draw),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [83:0] obs, input logic [83:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        exp_board = '0;
        for (int i = 0; i < 7; i++) hgt[i] = 0;
        exp_cur = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!drop_ready && n < 20) begin
            tick();
            n++;
        end
        if (!drop_ready) chk("ready_timeout", {83'd0, drop_ready}, 84'd1);
    endtask

    // One full legal turn; ends = this move finishes the game.
    task automatic play(input int col, input bit ends);
        wait_ready();
        drop_valid = 1'b1;
        drop_col   = 3'(col);
        tick();
        drop_valid = 1'b0;
        repeat (5) tick();
        chk("no_result_T6", {83'd0, game_over}, 84'd0);
        tick();
        exp_board[2*(7*hgt[col]+col) +: 2] = exp_cur ? 2'b10 : 2'b01;
        hgt[col]++;
        if (!ends) exp_cur = ~exp_cur;
        chk("board", board, exp_board);
        chk("cur_player", {83'd0, cur_player}, {83'd0, exp_cur});
    endtask

    task automatic illegal(input int col);
        wait_ready();
        drop_valid = 1'b1;
        drop_col   = 3'(col);
        tick();
        drop_valid = 1'b0;
        chk("err_T1", {83'd0, move_err}, 84'd1);
        chk("err_ready_T1", {83'd0, drop_ready}, 84'd0);
        chk("err_board", board, exp_board);
        chk("err_cur", {83'd0, cur_player}, {83'd0, exp_cur});
        tick();
        chk("err_T2", {83'd0, move_err}, 84'd0);
        chk("err_ready_T2", {83'd0, drop_ready}, 84'd1);
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_clear();
    endtask

    int ord_a [7] = '{0, 2, 1, 3, 4, 5, 6};
    int ord_b [7] = '{2, 0, 3, 1, 5, 4, 6};
    bit use_b [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; new_game = 1'b0; drop_valid = 1'b0; drop_col = 3'd0;
        model_clear();
        #2;
        chk("rst_ready", {83'd0, drop_ready}, 84'd1);
        chk("rst_board", board, 84'd0);
        chk("rst_over", {83'd0, game_over}, 84'd0);
        tick();
        chk("rst_hold_ready", {83'd0, drop_ready}, 84'd1);
        chk("rst_hold_cur", {83'd0, cur_player}, 84'd0);

        // Release reset with a drop pending: accepted on the first edge.
        rst = 1'b0; drop_valid = 1'b1; drop_col = 3'd0;
        tick();
        drop_valid = 1'b0;
        chk("first_accept", {83'd0, drop_ready}, 84'd0);
        repeat (6) tick();
        exp_board[1:0] = 2'b01; hgt[0] = 1; exp_cur = 1'b1;
        chk("first_board", board, exp_board);
        chk("first_cur", {83'd0, cur_player}, 84'd1);

        // Horizontal win for P1 on row 0.
        play(0, 0); play(1, 0); play(1, 0); play(2, 0); play(6, 0);
        play(3, 1);
        chk("h_win1", {83'd0, win1}, 84'd1);
        chk("h_win2", {83'd0, win2}, 84'd0);
        chk("h_over", {83'd0, game_over}, 84'd1);
        chk("h_ready", {83'd0, drop_ready}, 84'd0);
        drop_valid = 1'b1; drop_col = 3'd4;
        repeat (3) tick();
        drop_valid = 1'b0;
        chk("done_board", board, exp_board);
        chk("done_err", {83'd0, move_err}, 84'd0);
        chk("done_ready", {83'd0, drop_ready}, 84'd0);

        // Vertical win for P1 in column 4.
        start_new_game();
        chk("ng_clear", board, 84'd0);
        play(4, 0); play(5, 0); play(4, 0); play(5, 0); play(4, 0); play(5, 0);
        play(4, 1);
        chk("v_win1", {83'd0, win1}, 84'd1);
        chk("v_win2", {83'd0, win2}, 84'd0);
        chk("v_cell3", {82'd0, board[2*(7*3+4) +: 2]}, 84'd1);
        chk("v_cell0", {82'd0, board[2*4 +: 2]}, 84'd1);

        // Full column and out-of-range column.
        start_new_game();
        for (int i = 0; i < 6; i++) play(2, 0);
        illegal(2);
        illegal(7);
        play(0, 0);
        chk("after_err_cell", {82'd0, board[1:0]}, 84'd1);

        // new_game beats a simultaneous drop, then aborts a turn mid-scan.
        new_game = 1'b1; drop_valid = 1'b1; drop_col = 3'd3;
        tick();
        new_game = 1'b0; drop_valid = 1'b0;
        model_clear();
        chk("ngd_board", board, 84'd0);
        chk("ngd_cur", {83'd0, cur_player}, 84'd0);
        chk("ngd_ready", {83'd0, drop_ready}, 84'd1);
        chk("ngd_err", {83'd0, move_err}, 84'd0);
        tick();
        chk("ngd_no_accept", {83'd0, drop_ready}, 84'd1);
        drop_valid = 1'b1; drop_col = 3'd3;
        tick();
        drop_valid = 1'b0;
        tick();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("ngs_board", board, 84'd0);
        chk("ngs_cur", {83'd0, cur_player}, 84'd0);
        chk("ngs_ready", {83'd0, drop_ready}, 84'd1);
        chk("ngs_err", {83'd0, move_err}, 84'd0);
        repeat (7) tick();
        chk("ngs_discard", board, 84'd0);

        // 42-move draw with no four in a row or column.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 7; i++) begin
                play(use_b[r] ? ord_b[i] : ord_a[i], (r == 5) && (i == 6));
                if (r == 5 && i == 5) chk("draw41", {83'd0, draw}, 84'd0);
            end
        end
        chk("draw", {83'd0, draw}, 84'd1);
        chk("draw_win1", {83'd0, win1}, 84'd0);
        chk("draw_win2", {83'd0, win2}, 84'd0);
        chk("draw_over", {83'd0, game_over}, 84'd1);

        // Reset during SCAN_V of a winning vertical move.
        start_new_game();
        play(0, 0); play(1, 0); play(0, 0); play(1, 0); play(0, 0); play(1, 0);
        wait_ready();
        drop_valid = 1'b1; drop_col = 3'd0;
        tick();
        drop_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("arst_ready", {83'd0, drop_ready}, 84'd1);
        chk("arst_board", board, 84'd0);
        chk("arst_cur", {83'd0, cur_player}, 84'd0);
        chk("arst_flags", {79'd0, move_err, win1, win2, draw, game_over}, 84'd0);
        repeat (2) tick();
        chk("arst_hold_win1", {83'd0, win1}, 84'd0);
        chk("arst_hold_ready", {83'd0, drop_ready}, 84'd1);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
